// File: rtl/adc_scan_pkg.sv
// ADC scan sequencer shared definitions.
// Register map, CTRL/STATUS bit positions and FSM states.
package adc_scan_pkg;

  localparam logic [3:0] A_CTRL   = 4'd0;
  localparam logic [3:0] A_MASK   = 4'd1;
  localparam logic [3:0] A_SETTLE = 4'd2;
  localparam logic [3:0] A_STATUS = 4'd3;
  localparam logic [3:0] A_IRQ    = 4'd4;
  localparam logic [3:0] A_RES    = 4'd8;

  localparam int C_EN    = 0;
  localparam int C_CONT  = 1;
  localparam int C_START = 2;

  localparam int S_BUSY = 0;
  localparam int S_DONE = 1;
  localparam int S_CUR  = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SELECT,
    ST_SETTLE,
    ST_CONVERT,
    ST_STORE
  } state_e;

endpackage

// File: rtl/adc_next_channel.sv
// Priority finder: lowest set mask bit at or
// above index 'from'; 'found' low if none.
module adc_next_channel #(
  parameter int NUM_CH = 8,
  parameter int CH_W   = $clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] mask,
  input  logic [CH_W:0]     from,
  output logic [CH_W-1:0]   idx,
  output logic              found
);

  // scan downward so the lowest qualifying bit wins
  always_comb begin
    idx   = '0;
    found = 1'b0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (mask[i] && (i >= int'(from))) begin
        found = 1'b1;
        idx   = CH_W'(i);
      end
    end
  end

endmodule

// File: rtl/adc_scan_sequencer.sv
// Autonomous ADC channel scanner, Avalon-MM slave.
// Define ADC_SCAN_IRQ_EN to add the irq port.
module adc_scan_sequencer
  import adc_scan_pkg::*;
#(
  parameter int NUM_CH   = 8,
  parameter int DATA_W   = 12,
  parameter int SETTLE_W = 16,
  localparam int CH_W    = $clog2(NUM_CH)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [3:0]        address,
  input  logic              chipselect,
  input  logic              write_n,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  output logic [CH_W-1:0]   ch_sel,
  output logic              conv_start,
  input  logic              conv_done,
  input  logic [DATA_W-1:0] conv_data
`ifdef ADC_SCAN_IRQ_EN
  ,
  output logic              irq
`endif
);

  state_e state_q, state_d;
  logic en_q, en_d, cont_q, cont_d;
  logic done_q, done_d;
  logic [NUM_CH-1:0] mask_q, mask_d;
  logic [SETTLE_W-1:0] settle_q, settle_d;
  logic [SETTLE_W-1:0] cnt_q, cnt_d;
  logic [CH_W-1:0] ch_sel_q, ch_sel_d;
  logic cs_q, cs_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [DATA_W-1:0] result_q [NUM_CH];
  logic [DATA_W-1:0] result_d [NUM_CH];
  logic irqm_q, irqm_d;

  logic wr, start, busy;
  logic [CH_W-1:0] lo_idx, hi_idx;
  logic lo_found, hi_found;
  logic unused_wdata;

  assign wr    = chipselect & ~write_n;
  assign start = wr && (address == A_CTRL) &&
                 writedata[C_START] && writedata[C_EN];
  assign busy  = (state_q != ST_IDLE);
  assign unused_wdata = ^writedata;

  adc_next_channel #(
    .NUM_CH(NUM_CH), .CH_W(CH_W)
  ) u_lo (
    .mask(mask_q), .from('0),
    .idx(lo_idx), .found(lo_found)
  );

  adc_next_channel #(
    .NUM_CH(NUM_CH), .CH_W(CH_W)
  ) u_hi (
    .mask(mask_q),
    .from({1'b0, ch_sel_q} + 1'b1),
    .idx(hi_idx), .found(hi_found)
  );

  // register writes and scan FSM next state;
  // a scan-completion done set overrides W1C
  always_comb begin
    en_d     = en_q;
    cont_d   = cont_q;
    mask_d   = mask_q;
    settle_d = settle_q;
    done_d   = done_q;
    irqm_d   = irqm_q;
    state_d  = state_q;
    cnt_d    = cnt_q;
    ch_sel_d = ch_sel_q;
    cs_d     = 1'b0;
    data_d   = data_q;
    result_d = result_q;
    if (wr && address == A_CTRL) begin
      en_d   = writedata[C_EN];
      cont_d = writedata[C_CONT];
    end
    if (wr && address == A_MASK)
      mask_d = writedata[NUM_CH-1:0];
    if (wr && address == A_SETTLE)
      settle_d = writedata[SETTLE_W-1:0];
    if (wr && address == A_STATUS &&
        writedata[S_DONE])
      done_d = 1'b0;
`ifdef ADC_SCAN_IRQ_EN
    if (wr && address == A_IRQ)
      irqm_d = writedata[0];
`else
    irqm_d = 1'b0;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (start && lo_found) begin
          state_d  = ST_SELECT;
          ch_sel_d = lo_idx;
        end
      end
      ST_SELECT: begin
        cnt_d = settle_q;
        if (settle_q == '0) begin
          state_d = ST_CONVERT;
          cs_d    = 1'b1;
        end else begin
          state_d = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == SETTLE_W'(1)) begin
          state_d = ST_CONVERT;
          cs_d    = 1'b1;
        end
      end
      ST_CONVERT: begin
        if (conv_done) begin
          data_d  = conv_data;
          state_d = ST_STORE;
        end
      end
      ST_STORE: begin
        result_d[ch_sel_q] = data_q;
        if (!en_q) begin
          state_d = ST_IDLE;
        end else if (hi_found) begin
          state_d  = ST_SELECT;
          ch_sel_d = hi_idx;
        end else begin
          done_d = 1'b1;
          if (cont_q && lo_found) begin
            state_d  = ST_SELECT;
            ch_sel_d = lo_idx;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // state and register file
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      en_q     <= 1'b0;
      cont_q   <= 1'b0;
      done_q   <= 1'b0;
      irqm_q   <= 1'b0;
      mask_q   <= '0;
      settle_q <= '0;
      cnt_q    <= '0;
      ch_sel_q <= '0;
      cs_q     <= 1'b0;
      data_q   <= '0;
      for (int i = 0; i < NUM_CH; i++)
        result_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      en_q     <= en_d;
      cont_q   <= cont_d;
      done_q   <= done_d;
      irqm_q   <= irqm_d;
      mask_q   <= mask_d;
      settle_q <= settle_d;
      cnt_q    <= cnt_d;
      ch_sel_q <= ch_sel_d;
      cs_q     <= cs_d;
      data_q   <= data_d;
      result_q <= result_d;
    end
  end

  assign ch_sel     = ch_sel_q;
  assign conv_start = cs_q;

`ifdef ADC_SCAN_IRQ_EN
  logic irq_q;

  // level interrupt, one cycle behind done
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) irq_q <= 1'b0;
    else          irq_q <= done_q & irqm_q;
  end

  assign irq = irq_q;
`endif

  // zero-wait-state read mux
  always_comb begin
    readdata = '0;
    case (address)
      A_CTRL: begin
        readdata[C_EN]   = en_q;
        readdata[C_CONT] = cont_q;
      end
      A_MASK:   readdata = 32'(mask_q);
      A_SETTLE: readdata = 32'(settle_q);
      A_STATUS: begin
        readdata[S_BUSY]        = busy;
        readdata[S_DONE]        = done_q;
        readdata[S_CUR +: CH_W] = ch_sel_q;
      end
      A_IRQ:    readdata[0] = irqm_q;
      default: begin
        for (int i = 0; i < NUM_CH; i++)
          if (address == 4'(A_RES + i))
            readdata = 32'(result_q[i]);
      end
    endcase
  end

endmodule

// File: tb/tb_adc_scan_sequencer.sv
// Bench for adc_scan_sequencer: register vectors,
// converter model, channel/timing scoreboard.
module tb_adc_scan_sequencer;
  import adc_scan_pkg::*;

  localparam int LAT = 2;
`ifdef ADC_SCAN_IRQ_EN
  localparam logic [31:0] IRQ_RB = 32'd1;
`else
  localparam logic [31:0] IRQ_RB = 32'd0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n;
  logic [3:0]  address;
  logic        chipselect, write_n;
  logic [31:0] writedata, readdata;
  logic [2:0]  ch_sel;
  logic        conv_start, conv_done;
  logic [11:0] conv_data;
  logic        model_done, man_done;
  logic [11:0] model_data, man_data;
`ifdef ADC_SCAN_IRQ_EN
  logic        irq;
`endif

  assign conv_done = model_done | man_done;
  assign conv_data = man_done ? man_data : model_data;

  adc_scan_sequencer dut (
    .clk(clk), .reset_n(reset_n),
    .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata),
    .readdata(readdata), .ch_sel(ch_sel),
    .conv_start(conv_start),
    .conv_done(conv_done), .conv_data(conv_data)
`ifdef ADC_SCAN_IRQ_EN
    , .irq(irq)
`endif
  );

  typedef struct {
    logic [2:0]  ch;
    int          cyc;
    logic [11:0] data;
  } obs_t;

  typedef struct {
    logic [3:0]  a;
    logic        w;
    logic [31:0] wd;
    logic [31:0] rd;
  } vec_t;

  int cyc = 0;
  int n_err = 0, n_chk = 0;
  int wr_cyc, first_cs;
  bit model_en;
  obs_t obs_q[$];
  logic [2:0] exp_ch[$];
  logic [11:0] exp_res [8];
  vec_t vt [16];

  always @(posedge clk) cyc <= cyc + 1;

  // converter model: answers each conv_start
  // LAT cycles later with random data
  initial begin
    obs_t o;
    model_done = 1'b0;
    model_data = '0;
    forever begin
      @(negedge clk);
      model_done = 1'b0;
      if (model_en && conv_start) begin
        o.ch   = ch_sel;
        o.cyc  = cyc;
        o.data = 12'($urandom);
        obs_q.push_back(o);
        repeat (LAT) @(negedge clk);
        model_done = 1'b1;
        model_data = o.data;
      end
    end
  end

  initial begin
    #500us;
    $display("FAIL watchdog: time limit hit");
    $fatal(1);
  end

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h want 0x%0h",
               nm, act, exp);
    end
  endtask

  task automatic wr(input logic [3:0] a,
                    input logic [31:0] d);
    @(negedge clk);
    address = a; writedata = d;
    chipselect = 1'b1; write_n = 1'b0;
    @(posedge clk);
    #1;
    wr_cyc = cyc;
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic rd(input logic [3:0] a,
                    output logic [31:0] d);
    @(negedge clk);
    address = a;
    #1;
    d = readdata;
  endtask

  task automatic wait_st(input logic [31:0] m,
                         input logic [31:0] v,
                         input string nm,
                         output logic [31:0] d);
    int k;
    for (k = 0; k < 300; k++) begin
      rd(A_STATUS, d);
      if ((d & m) == v) break;
    end
    chk({nm, "_timeout"}, 32'(k < 300), 32'd1);
  endtask

  task automatic drain(input int s, input int n,
                       input string nm);
    obs_t o;
    logic [2:0] e;
    int ec;
    ec = first_cs;
    chk({nm, "_count"}, obs_q.size(), n);
    while (obs_q.size() > 0) begin
      o = obs_q.pop_front();
      e = (exp_ch.size() > 0) ?
          exp_ch.pop_front() : 3'bx;
      chk({nm, "_ch"}, 32'(o.ch), 32'(e));
      chk({nm, "_cyc"}, o.cyc, ec);
      exp_res[o.ch] = o.data;
      ec += LAT + 3 + s;
    end
    exp_ch.delete();
  endtask

  task automatic chk_res(input string nm);
    logic [31:0] d;
    for (int i = 0; i < 8; i++) begin
      rd(4'(A_RES + i), d);
      chk($sformatf("%s_res%0d", nm, i),
          d, 32'(exp_res[i]));
    end
  endtask

  initial begin
    logic [31:0] d;
    int k;
    reset_n = 1'b0;
    address = '0; writedata = '0;
    chipselect = 1'b0; write_n = 1'b1;
    man_done = 1'b0; man_data = '0;
    model_en = 1'b1;
    for (int i = 0; i < 8; i++) exp_res[i] = '0;

    vt[0]  = '{A_CTRL,   1'b0, 32'h0, 32'h0};
    vt[1]  = '{A_MASK,   1'b0, 32'h0, 32'h0};
    vt[2]  = '{A_SETTLE, 1'b0, 32'h0, 32'h0};
    vt[3]  = '{A_STATUS, 1'b0, 32'h0, 32'h0};
    vt[4]  = '{A_IRQ,    1'b0, 32'h0, 32'h0};
    vt[5]  = '{A_RES,    1'b0, 32'h0, 32'h0};
    vt[6]  = '{A_MASK,   1'b1,
               32'hFFFF_FF5A, 32'h5A};
    vt[7]  = '{A_SETTLE, 1'b1,
               32'hABCD_1234, 32'h1234};
    vt[8]  = '{A_CTRL,   1'b1,
               32'hFFFF_FFFA, 32'h2};
    vt[9]  = '{A_CTRL,   1'b1, 32'h6, 32'h2};
    vt[10] = '{A_STATUS, 1'b0, 32'h0, 32'h0};
    vt[11] = '{4'd5,     1'b1,
               32'hFFFF_FFFF, 32'h0};
    vt[12] = '{A_IRQ,    1'b1, 32'h1, IRQ_RB};
    vt[13] = '{4'd11,    1'b1, 32'h123, 32'h0};
    vt[14] = '{A_STATUS, 1'b1,
               32'hFFFF_FFFF, 32'h0};
    vt[15] = '{A_IRQ,    1'b1, 32'h0, 32'h0};

    repeat (3) @(negedge clk);
    chk("rst_ch_sel", 32'(ch_sel), 0);
    chk("rst_conv_start", 32'(conv_start), 0);
`ifdef ADC_SCAN_IRQ_EN
    chk("rst_irq", 32'(irq), 0);
`endif
    reset_n = 1'b1;

    for (int i = 0; i < 16; i++) begin
      if (vt[i].w) wr(vt[i].a, vt[i].wd);
      rd(vt[i].a, d);
      chk($sformatf("vec%0d", i), d, vt[i].rd);
    end
    chk("vec_no_conv", obs_q.size(), 0);

    // two-channel single scan, settle 3
    wr(A_MASK, 32'h05);
    wr(A_SETTLE, 32'd3);
    exp_ch.push_back(3'd0);
    exp_ch.push_back(3'd2);
    wr(A_CTRL, 32'h5);
    first_cs = wr_cyc + 1 + 3;
    rd(A_STATUS, d);
    chk("t1_busy", 32'(d[S_BUSY]), 1);
    wr(A_CTRL, 32'h5);
    wait_st(32'h1, 32'h0, "t1_idle", d);
    drain(3, 2, "t1");
    rd(A_STATUS, d);
    chk("t1_status", d & 32'h3, 32'h2);
    chk_res("t1");
    wr(A_STATUS, 32'h2);
    rd(A_STATUS, d);
    chk("t1_w1c", d & 32'h3, 32'h0);

    // continuous 0,7,0,7 then disable
    wr(A_SETTLE, 32'd2);
    wr(A_MASK, 32'h81);
    for (int i = 0; i < 2; i++) begin
      exp_ch.push_back(3'd0);
      exp_ch.push_back(3'd7);
    end
    wr(A_CTRL, 32'h7);
    first_cs = wr_cyc + 1 + 2;
    wait_st(32'h2, 32'h2, "t2_done", d);
    chk("t2_busy_cont", 32'(d[S_BUSY]), 1);
    chk("t2_pass1", obs_q.size(), 2);
    wr(A_STATUS, 32'h2);
    for (k = 0; k < 300; k++) begin
      if (obs_q.size() >= 4) break;
      @(negedge clk);
    end
    chk("t2_four_timeout", 32'(k < 300), 1);
    wr(A_CTRL, 32'h2);
    wait_st(32'h1, 32'h0, "t2_idle", d);
    repeat (20) @(negedge clk);
    drain(2, 4, "t2");
    rd(A_STATUS, d);
    chk("t2_no_done", d & 32'h3, 32'h0);
    chk_res("t2");

    // zero settle: convert right after select
    wr(A_SETTLE, 32'd0);
    wr(A_MASK, 32'h01);
    exp_ch.push_back(3'd0);
    wr(A_CTRL, 32'h5);
    first_cs = wr_cyc + 1;
    wait_st(32'h1, 32'h0, "t3_idle", d);
    drain(0, 1, "t3");
    chk_res("t3");
    wr(A_STATUS, 32'h2);

    // start ignored: empty mask, then no enable
    wr(A_MASK, 32'h0);
    wr(A_CTRL, 32'h5);
    repeat (20) @(negedge clk);
    rd(A_STATUS, d);
    chk("t4_mask0", d & 32'h3, 32'h0);
    chk("t4_mask0_conv", obs_q.size(), 0);
    wr(A_MASK, 32'h1);
    wr(A_CTRL, 32'h4);
    repeat (20) @(negedge clk);
    rd(A_STATUS, d);
    chk("t4_noen", d & 32'h3, 32'h0);
    chk("t4_noen_conv", obs_q.size(), 0);

    // reset during CONVERT, late conv_done
    model_en = 1'b0;
    wr(A_SETTLE, 32'd1);
    wr(A_MASK, 32'h04);
    wr(A_CTRL, 32'h5);
    for (k = 0; k < 50; k++) begin
      @(negedge clk);
      if (conv_start) break;
    end
    chk("t5_cs_timeout", 32'(k < 50), 1);
    chk("t5_ch_pre", 32'(ch_sel), 2);
    reset_n = 1'b0;
    #1;
    chk("t5_ch_rst", 32'(ch_sel), 0);
    chk("t5_cs_rst", 32'(conv_start), 0);
`ifdef ADC_SCAN_IRQ_EN
    chk("t5_irq_rst", 32'(irq), 0);
`endif
    rd(A_STATUS, d);
    chk("t5_status_rst", d, 0);
    @(negedge clk);
    reset_n = 1'b1;
    man_data = 12'hABC;
    man_done = 1'b1;
    @(negedge clk);
    man_done = 1'b0;
    repeat (5) @(negedge clk);
    rd(A_STATUS, d);
    chk("t5_status_post", d, 0);
    chk("t5_cs_post", 32'(conv_start), 0);
    for (int i = 0; i < 8; i++) exp_res[i] = '0;
    chk_res("t5");
    model_en = 1'b1;

`ifdef ADC_SCAN_IRQ_EN
    // irq follows done by one cycle
    wr(A_IRQ, 32'h1);
    wr(A_MASK, 32'h01);
    exp_ch.push_back(3'd0);
    wr(A_CTRL, 32'h5);
    first_cs = wr_cyc + 1;
    wait_st(32'h2, 32'h2, "t6_done", d);
    chk("t6_irq_lag", 32'(irq), 0);
    @(negedge clk);
    #1;
    chk("t6_irq_hi", 32'(irq), 1);
    wr(A_STATUS, 32'h2);
    rd(A_STATUS, d);
    chk("t6_done_clr", d & 32'h2, 0);
    @(negedge clk);
    #1;
    chk("t6_irq_lo", 32'(irq), 0);
    drain(0, 1, "t6");
`endif

    $display("Result: errors=%0d of %0d checks",
             n_err, n_chk);
    $finish;
  end

endmodule
